ps2_key_receiver: RTL and testbench
===================================

PS2_KEY_RECEIVER -- requirements
Module: ps2_key_receiver

Interface
REQ-001 Parameter D_WIDTH, default 8, key code width; only 8 is supported.
REQ-002 Parameter FILTER_LEN, default 8, number of consecutive equal synchronized samples required to change the filtered ps2_clk level.
REQ-003 Parameter TIMEOUT_CYCLES, default 50000, clk cycles without a filtered ps2_clk falling edge before a partial frame is abandoned.
REQ-004 clk  input  1  system clock; the block uses one clock only.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 ps2_clk  input  1  PS/2 device clock, asynchronous to clk.
REQ-007 ps2_data  input  1  PS/2 device data, asynchronous to clk.
REQ-008 key_code  output  D_WIDTH  last completed scan code, prefix bytes stripped.
REQ-009 en  output  1  one-cycle pulse for a make code; key_code is valid in the same cycle.
REQ-010 key_release  output  1  one-cycle pulse for a break code (F0-prefixed); key_code is valid in the same cycle.
REQ-011 extended  output  1  high when the current key_code was E0-prefixed; held until the next en or key_release.
REQ-012 frame_err  output  1  one-cycle pulse on a parity error, a stop-bit error or a timeout.

Function
REQ-013 ps2_clk and ps2_data shall each pass through a 2-flop synchronizer.
REQ-014 The filtered ps2_clk level shall change only after FILTER_LEN consecutive synchronized samples agree; the filter resets to 1.
REQ-015 A bit shall be sampled from synchronized ps2_data in the cycle the filtered ps2_clk goes from 1 to 0.
REQ-016 The frame FSM shall have states IDLE, DATA, PARITY and STOP.
REQ-017 In IDLE, a sampled 0 shall move the FSM to DATA; a sampled 1 shall leave it in IDLE with no error.
REQ-018 DATA shall shift in 8 bits, LSB first, using a 3-bit counter, then move to PARITY.
REQ-019 In PARITY the bit shall be captured; the 8 data bits plus the parity bit must hold an odd number of ones.
REQ-020 In STOP a sampled 1 with good parity completes the byte; in all STOP cases the FSM returns to IDLE.
REQ-021 A bad parity bit or a sampled stop bit of 0 shall pulse frame_err, discard the byte, and clear the F0 and E0 pending flags.
REQ-022 In any state other than IDLE, TIMEOUT_CYCLES clk cycles without a falling edge shall return the FSM to IDLE, pulse frame_err and clear the pending flags. The timeout counter restarts on every edge.
REQ-023 A completed byte of 8'hE0 shall set the ext_pend flag; no output pulse.
REQ-024 A completed byte of 8'hF0 shall set the brk_pend flag; no output pulse. E0 followed by F0 sets both flags.
REQ-025 Any other completed byte shall:
  - load key_code with the byte;
  - load extended from ext_pend;
  - pulse key_release if brk_pend is set, otherwise pulse en;
  - clear both pending flags.
REQ-026 Latency: en or key_release shall assert exactly 1 clk cycle after the cycle in which the stop-bit falling edge was detected.
REQ-027 en and key_release shall never assert in the same cycle; each shall be high for exactly one cycle per byte.
REQ-028 key_code and extended shall hold their values between pulses.
REQ-029 A new frame may start in the cycle after STOP; back-to-back frames shall not be lost.

Reset
REQ-030 While rst is high, the block shall enter and hold the following state:
  - FSM = IDLE; bit counter = 0; timeout counter = 0;
  - pending flags cleared; synchronizers and filter = 1;
  - key_code = 0; en, key_release, extended and frame_err = 0.
REQ-031 rst asserted mid-frame shall discard the partial frame; no pulse shall follow reset.

Verification
REQ-032 Frame 0x1D (start 0, bits 1,0,1,1,1,0,0,0, parity 1, stop 1) -> key_code=0x1D, en high 1 cycle, key_release=0, extended=0.
REQ-033 Frames F0 then 1D -> no pulse after F0; after 1D, key_release high 1 cycle, key_code=0x1D, en never high.
REQ-034 Frames E0 then 74 -> en pulse, key_code=0x74, extended=1; a following frame 23 -> en pulse, extended=0.
REQ-035 Frame 0x24 with inverted parity -> frame_err pulse, no en; a following good frame 0x24 -> en pulse with key_code=0x24.
REQ-036 Stop after 4 data bits for TIMEOUT_CYCLES+2 cycles -> frame_err pulse, FSM in IDLE; a following frame 0x5A -> en pulse, key_code=0x5A.
REQ-037 Mid-frame: glitch shorter than FILTER_LEN on ps2_clk -> no extra bit sampled. rst pulse mid-frame -> all outputs 0; a following frame 0x6B -> en pulse, key_code=0x6B.

Source files
------------

// File: rtl/ps2_key_receiver_if.sv
// PS/2 receiver bus: device-side lines in, decoded key events out.
// The receiver takes the slave view; the line driver (device model) takes master.
interface ps2_key_receiver_if #(
    parameter int D_WIDTH = 8
);
    logic               ps2_clk;
    logic               ps2_data;
    logic [D_WIDTH-1:0] key_code;
    logic               en;
    logic               key_release;
    logic               extended;
    logic               frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  key_code,
        input  en,
        input  key_release,
        input  extended,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output key_code,
        output en,
        output key_release,
        output extended,
        output frame_err
    );
endinterface

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the device lines,
// deframes 11-bit frames and decodes E0/F0 prefixes into key events.
module ps2_key_receiver #(
    parameter int D_WIDTH        = 8,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic               clk,
    input logic               rst,
    ps2_key_receiver_if.slave bus
);

    localparam int FILT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [D_WIDTH-1:0] CODE_EXT = D_WIDTH'(8'hE0);
    localparam logic [D_WIDTH-1:0] CODE_BRK = D_WIDTH'(8'hF0);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic              ps2_clk_s1;
    logic              ps2_clk_s2;
    logic              ps2_data_s1;
    logic              ps2_data_s2;
    logic              clk_filt;
    logic [FILT_W-1:0] filt_cnt;
    logic              fall;

    state_t             state;
    logic [2:0]         bit_cnt;
    logic [D_WIDTH-1:0] shift;
    logic               par_bit;
    logic [TO_W-1:0]    to_cnt;
    logic               ext_pend;
    logic               brk_pend;

    logic [D_WIDTH-1:0] key_code_q;
    logic               en_q;
    logic               key_release_q;
    logic               extended_q;
    logic               frame_err_q;

    // Synchronizers and the ps2_clk level filter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ps2_clk_s1  <= 1'b1;
            ps2_clk_s2  <= 1'b1;
            ps2_data_s1 <= 1'b1;
            ps2_data_s2 <= 1'b1;
            clk_filt    <= 1'b1;
            filt_cnt    <= '0;
        end else begin
            ps2_clk_s1  <= bus.ps2_clk;
            ps2_clk_s2  <= ps2_clk_s1;
            ps2_data_s1 <= bus.ps2_data;
            ps2_data_s2 <= ps2_data_s1;
            if (ps2_clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_W'(FILTER_LEN - 1)) begin
                clk_filt <= ps2_clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FILT_W'(1);
            end
        end
    end

    // The falling edge is recognised in the same cycle the filter flips,
    // so the bit is sampled without an extra pipeline stage.
    always_comb begin
        fall = clk_filt && !ps2_clk_s2 && (filt_cnt == FILT_W'(FILTER_LEN - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            par_bit       <= 1'b0;
            to_cnt        <= '0;
            ext_pend      <= 1'b0;
            brk_pend      <= 1'b0;
            key_code_q    <= '0;
            en_q          <= 1'b0;
            key_release_q <= 1'b0;
            extended_q    <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            en_q          <= 1'b0;
            key_release_q <= 1'b0;
            frame_err_q   <= 1'b0;

            if (state != IDLE && !fall && to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state       <= IDLE;
                bit_cnt     <= '0;
                to_cnt      <= '0;
                frame_err_q <= 1'b1;
                ext_pend    <= 1'b0;
                brk_pend    <= 1'b0;
            end else begin
                if (state == IDLE || fall) begin
                    to_cnt <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end

                if (fall) begin
                    case (state)
                        IDLE: begin
                            if (!ps2_data_s2) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end
                        end
                        DATA: begin
                            shift   <= {ps2_data_s2, shift[D_WIDTH-1:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state <= PARITY;
                            end
                        end
                        PARITY: begin
                            par_bit <= ps2_data_s2;
                            state   <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            if (ps2_data_s2 && (^{shift, par_bit})) begin
                                if (shift == CODE_EXT) begin
                                    ext_pend <= 1'b1;
                                end else if (shift == CODE_BRK) begin
                                    brk_pend <= 1'b1;
                                end else begin
                                    key_code_q    <= shift;
                                    extended_q    <= ext_pend;
                                    key_release_q <= brk_pend;
                                    en_q          <= !brk_pend;
                                    ext_pend      <= 1'b0;
                                    brk_pend      <= 1'b0;
                                end
                            end else begin
                                frame_err_q <= 1'b1;
                                ext_pend    <= 1'b0;
                                brk_pend    <= 1'b0;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.key_code    = key_code_q;
    assign bus.en          = en_q;
    assign bus.key_release = key_release_q;
    assign bus.extended    = extended_q;
    assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Bench for ps2_key_receiver: drives PS/2 frames and checks decoded events
// against a frame-level model that predicts each event's exact cycle.
module tb_ps2_key_receiver;

    localparam int FL   = 4;
    localparam int TO   = 200;
    localparam int HALF = 20;
    localparam int LAT  = FL + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b1;
    int   cyc = 0;

    int checks = 0;
    int failures = 0;

    ps2_key_receiver_if #(.D_WIDTH(8)) bus ();

    ps2_key_receiver #(
        .D_WIDTH(8),
        .FILTER_LEN(FL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // Expected key events and frame-error windows, produced by the stimulus.
    int         ev_due [128];
    logic [7:0] ev_code[128];
    bit         ev_rel [128];
    bit         ev_ext [128];
    int         wr = 0;
    int         rd = 0;
    int         err_lo [32];
    int         err_hi [32];
    int         ewr = 0;
    int         erd = 0;

    bit ext_p = 1'b0;
    bit brk_p = 1'b0;

    logic [7:0] mkey = 8'h00;
    bit         mext = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        bit exp_en;
        bit exp_rel;
        forever begin
            @(negedge clk);
            if (rst_q) begin
                chk("reset_outputs",
                    {19'd0, bus.key_code, bus.en, bus.key_release, bus.extended, bus.frame_err},
                    32'd0);
                mkey = 8'h00;
                mext = 1'b0;
                rd   = wr;
                erd  = ewr;
            end else begin
                exp_en  = 1'b0;
                exp_rel = 1'b0;
                if (rd != wr && ev_due[rd] == cyc) begin
                    exp_en  = !ev_rel[rd];
                    exp_rel = ev_rel[rd];
                    mkey    = ev_code[rd];
                    mext    = ev_ext[rd];
                    rd++;
                end
                chk("en_release_pulse", {30'd0, bus.en, bus.key_release}, {30'd0, exp_en, exp_rel});
                chk("key_code_ext", {23'd0, bus.key_code, bus.extended}, {23'd0, mkey, mext});
                if (bus.frame_err) begin
                    if (erd != ewr && cyc >= err_lo[erd] && cyc <= err_hi[erd]) begin
                        chk("frame_err_expected", 32'd1, 32'd1);
                        erd++;
                    end else begin
                        chk("frame_err_spurious", 32'd1, 32'd0);
                    end
                end else if (erd != ewr && cyc >= err_hi[erd]) begin
                    chk("frame_err_missed", 32'd0, 32'd1);
                    erd++;
                end
            end
        end
    endtask

    task automatic push_ev(input int due, input logic [7:0] code, input bit rel, input bit ext);
        ev_due[wr]  = due;
        ev_code[wr] = code;
        ev_rel[wr]  = rel;
        ev_ext[wr]  = ext;
        wr++;
    endtask

    task automatic push_err(input int lo, input int hi);
        err_lo[ewr] = lo;
        err_hi[ewr] = hi;
        ewr++;
    endtask

    // Clock high half of one bit with data set; optional short clock glitch.
    task automatic bit_high(input logic b, input bit glitch);
        bus.ps2_data = b;
        if (glitch) begin
            repeat (5) @(negedge clk);
            bus.ps2_clk = 1'b0;
            repeat (FL - 2) @(negedge clk);
            bus.ps2_clk = 1'b1;
            repeat (HALF - 5 - (FL - 2)) @(negedge clk);
        end else begin
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic bit_fall();
        bus.ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int glitch_bit, input int gap);
        logic [10:0] fr;
        logic        par;
        int          due;
        par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
        if (bad_par) par = ~par;
        fr = {~bad_stop, par, b, 1'b0};
        @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            bit_high(fr[i], i == glitch_bit);
            if (i == 10) begin
                due = cyc + LAT;
                if (bad_par || bad_stop) begin
                    push_err(due, due);
                    ext_p = 1'b0;
                    brk_p = 1'b0;
                end else if (b == 8'hE0) begin
                    ext_p = 1'b1;
                end else if (b == 8'hF0) begin
                    brk_p = 1'b1;
                end else begin
                    push_ev(due, b, brk_p, ext_p);
                    ext_p = 1'b0;
                    brk_p = 1'b0;
                end
            end
            bit_fall();
        end
        if (gap > 0) begin
            bus.ps2_data = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic send_partial(input int nbits, output int last_due);
        last_due = 0;
        @(negedge clk);
        for (int i = 0; i <= nbits; i++) begin
            bit_high((i == 0) ? 1'b0 : i[0], 1'b0);
            last_due = cyc + LAT;
            bit_fall();
        end
        bus.ps2_data = 1'b1;
    endtask

    task automatic good(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, -1, 10);
    endtask

    initial begin
        int d;
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        fork
            monitor();
        join_none
        repeat (5) @(negedge clk);
        chk("lit_reset", {19'd0, bus.key_code, bus.en, bus.key_release, bus.extended, bus.frame_err}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        good(8'h1D);
        chk("lit_1d_code", {24'd0, bus.key_code}, 32'h1D);
        chk("lit_1d_ext", {31'd0, bus.extended}, 32'd0);

        good(8'hF0);
        good(8'h1D);
        chk("lit_f0_1d_code", {24'd0, bus.key_code}, 32'h1D);

        good(8'hE0);
        good(8'h74);
        chk("lit_e0_74_code", {24'd0, bus.key_code}, 32'h74);
        chk("lit_e0_74_ext", {31'd0, bus.extended}, 32'd1);
        good(8'h23);
        chk("lit_23_ext", {31'd0, bus.extended}, 32'd0);

        good(8'hE0);
        good(8'hF0);
        good(8'h75);
        chk("lit_e0_f0_75_ext", {31'd0, bus.extended}, 32'd1);

        good(8'hF0);
        send_frame(8'h24, 1'b1, 1'b0, -1, 10);
        good(8'h24);
        chk("lit_24_after_parity_err", {23'd0, bus.key_code, bus.extended}, {23'd0, 8'h24, 1'b0});

        send_frame(8'h2B, 1'b0, 1'b1, -1, 10);
        good(8'h2B);

        good(8'hE0);
        send_partial(4, d);
        push_err(d + TO - 2, d + TO + 2);
        ext_p = 1'b0;
        brk_p = 1'b0;
        repeat (TO + 30) @(negedge clk);
        good(8'h5A);
        chk("lit_5a_after_timeout", {23'd0, bus.key_code, bus.extended}, {23'd0, 8'h5A, 1'b0});

        send_frame(8'h33, 1'b0, 1'b0, 3, 10);
        chk("lit_33_glitch", {24'd0, bus.key_code}, 32'h33);

        send_frame(8'h16, 1'b0, 1'b0, -1, 0);
        send_frame(8'h1E, 1'b0, 1'b0, -1, 0);
        good(8'h26);
        chk("lit_back_to_back", {24'd0, bus.key_code}, 32'h26);

        good(8'hF0);
        send_partial(3, d);
        @(negedge clk);
        rst = 1'b1;
        ext_p = 1'b0;
        brk_p = 1'b0;
        repeat (3) @(negedge clk);
        chk("lit_mid_reset", {19'd0, bus.key_code, bus.en, bus.key_release, bus.extended, bus.frame_err}, 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        good(8'h6B);
        chk("lit_6b_after_reset", {23'd0, bus.key_code, bus.extended}, {23'd0, 8'h6B, 1'b0});

        repeat (TO + 20) @(negedge clk);
        chk("events_outstanding", rd, wr);
        chk("errors_outstanding", erd, ewr);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
